// File: rtl/x_result_accum_if.sv
// Handshake bundle between the X_system_v result stream, the batch controller
// and the summary consumer of x_result_accum.
interface x_result_accum_if #(
    parameter int Z_W   = 22,
    parameter int CNT_W = 4,
    parameter int ACC_W = 26
);
    // Batch request
    logic             start;
    logic [CNT_W-1:0] count;
    logic             z_type;   // 1 = Z is two's-complement signed

    // Sample stream
    logic             in_valid;
    logic             in_ready;
    logic [Z_W-1:0]   Z;
    logic [1:0]       Sel;

    // Batch summary
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic [Z_W-1:0]   max;
    logic             sel_mismatch;
    logic             busy;

    modport master (
        output start, count, z_type, in_valid, Z, Sel, out_ready,
        input  in_ready, out_valid, sum, max, sel_mismatch, busy
    );

    modport slave (
        input  start, count, z_type, in_valid, Z, Sel, out_ready,
        output in_ready, out_valid, sum, max, sel_mismatch, busy
    );
endinterface

// File: rtl/x_result_accum.sv
// Batch accumulator for X_system_v results: sums N samples, tracks the running
// maximum and a sticky Sel-change flag, and presents one summary per start.
module x_result_accum #(
    parameter int Z_W   = 22,
    parameter int CNT_W = 4,
    parameter int ACC_W = 26
) (
    input  logic               clk,
    input  logic               rst,
    x_result_accum_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] remain_q,    remain_d;
    logic             type_q,      type_d;
    logic [1:0]       sel_q,       sel_d;
    logic             have_first_q, have_first_d;
    logic [ACC_W-1:0] sum_q,       sum_d;
    logic [Z_W-1:0]   max_q,       max_d;
    logic             mismatch_q,  mismatch_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic             accept;
    logic [ACC_W-1:0] z_ext;
    logic             z_gt_max;

    assign accept = bus.in_valid && in_ready_q;

    // Extension and ordering both follow the type latched at start, not the live input.
    assign z_ext    = type_q ? {{(ACC_W-Z_W){bus.Z[Z_W-1]}}, bus.Z}
                             : {{(ACC_W-Z_W){1'b0}},         bus.Z};
    assign z_gt_max = type_q ? ($signed(bus.Z) > $signed(max_q))
                             : (bus.Z > max_q);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned; that is what keeps this block from inferring latches.
        state_d      = state_q;
        remain_d     = remain_q;
        type_d       = type_q;
        sel_d        = sel_q;
        have_first_d = have_first_q;
        sum_d        = sum_q;
        max_d        = max_q;
        mismatch_d   = mismatch_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sum_d        = '0;
                    max_d        = '0;
                    mismatch_d   = 1'b0;
                    have_first_d = 1'b0;
                    type_d       = bus.z_type;
                    remain_d     = bus.count;
                    state_d      = (bus.count == '0) ? DONE : ACCUM;
                end
            end

            ACCUM: begin
                if (accept) begin
                    sum_d    = sum_q + z_ext;
                    remain_d = remain_q - CNT_W'(1);
                    if (!have_first_q) begin
                        max_d        = bus.Z;
                        sel_d        = bus.Sel;
                        have_first_d = 1'b1;
                    end else begin
                        if (z_gt_max) begin
                            max_d = bus.Z;
                        end
                        if (bus.Sel != sel_q) begin
                            mismatch_d = 1'b1;
                        end
                    end
                    if (remain_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state, so they switch
        // on the same edge as the state itself.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: the async reset clears every flop, datapath included, so a reset
    // mid-batch leaves no stale sum, max or tag behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            remain_q     <= '0;
            type_q       <= 1'b0;
            sel_q        <= 2'b00;
            have_first_q <= 1'b0;
            sum_q        <= '0;
            max_q        <= '0;
            mismatch_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of every other flop, independent of statement order.
            state_q      <= state_d;
            remain_q     <= remain_d;
            type_q       <= type_d;
            sel_q        <= sel_d;
            have_first_q <= have_first_d;
            sum_q        <= sum_d;
            max_q        <= max_d;
            mismatch_q   <= mismatch_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.busy         = busy_q;
    assign bus.sum          = sum_q;
    assign bus.max          = max_q;
    assign bus.sel_mismatch = mismatch_q;

endmodule

// File: doc/x_result_accum.md
Name: x_result_accum

Overview:
Downstream consumer of the X_system_v function unit. It captures the 22-bit result Z over a valid/ready handshake and accumulates a programmed number of results into a sum. It also tracks the running maximum and flags whether the Sel tag changed within a batch. One batch summary is presented per start request, so the bench or host reads one word instead of sampling Z every 1000 ms step.

Parameters:
Z_W, 22, width of incoming result Z
CNT_W, 4, width of the batch-length field (max batch 2^CNT_W-1 = 15)
ACC_W, 26, accumulator width (Z_W+CNT_W; no overflow possible for a full batch)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle batch request, honoured only in IDLE
count  input  CNT_W  batch length N, sampled with start
type  input  1  1 = Z is two's-complement signed, 0 = unsigned; sampled with start
in_valid  input  1  Z/Sel valid from upstream
in_ready  output  1  block accepts a sample this cycle
Z  input  Z_W  result from X_system_v
Sel  input  2  function tag accompanying Z
out_valid  output  1  batch summary valid
out_ready  input  1  consumer takes the summary
sum  output  ACC_W  sum of N samples, extended per latched type
max  output  Z_W  largest sample, compared per latched type
sel_mismatch  output  1  sticky: some sample's Sel differed from the first sample's Sel
busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (async, any time including mid-batch): state=IDLE. in_ready, out_valid, busy, sel_mismatch = 0. sum = 0, max = 0. Remaining count, latched type and latched Sel = 0.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0, busy=0.
  - start with count!=0: latch count and type, clear sum, max, sel_mismatch and the first-sample flag, go to ACCUM.
  - start with count==0: clear sum and max, go directly to DONE. The empty batch reports sum=0, max=0, mismatch=0.
- ACCUM: in_ready=1, busy=1. A sample is accepted when in_valid && in_ready.
  - Accepted sample: sum <= sum + ext(Z). ext is sign-extension to ACC_W when latched type=1, zero-extension when 0.
  - max: the first accepted sample loads max directly. Later samples replace max if larger, using a signed compare when type=1 and unsigned otherwise. Ties keep the current value.
  - Sel: the first sample latches Sel. Any later accepted sample with a different Sel sets sel_mismatch, which stays set until the next start.
  - The remaining count decrements on each accept. The accept that takes it from 1 to 0 moves the block to DONE. in_ready falls in the next cycle, so exactly N samples are consumed.
  - A cycle with in_valid=0 does not change state.
- DONE: out_valid=1, busy=1, in_ready=0.
  - sum, max and sel_mismatch hold stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE. Outputs retain their values until the next start.
- Latency: out_valid rises one cycle after the clock edge that accepts the last sample. An empty batch reaches DONE one cycle after start.
- start is ignored in ACCUM and DONE. The type and count inputs are ignored except in the start cycle.
- sum is interpreted as signed when the latched type=1 and as unsigned otherwise; there is no saturation and no wrap for N ≤ 15.

Test Plan:
- Signed batch: start, count=3, type=1; Z = 22'h3FFFFF, 22'h000005, 22'h3FFFFD, all with Sel=01, back-to-back -> out_valid one cycle after the 3rd accept; sum=26'h0000001, max=22'h000005, sel_mismatch=0.
- Unsigned batch: same Z values, type=0 -> sum=26'h0800001, max=22'h3FFFFF.
- Full signed batch: count=15, type=1, all Z=22'h200000 -> sum=26'h2200000 (−31457280), max=22'h200000. Also check in_ready=0 after the 15th accept while a 16th in_valid is held high.
- Handshake and tags: count=2, in_valid gapped (idle cycles between samples), Sel=00 then 11 -> exactly 2 accepts, sel_mismatch=1. Hold out_ready=0 for 5 cycles -> outputs stable and start ignored. Then out_ready=1 -> IDLE next cycle.
- Empty batch: start with count=0 -> out_valid one cycle later with sum=0, max=0, and no in_ready pulse.
- Reset mid-operation: assert rst after the 1st of 3 samples -> all outputs 0 immediately (async). A following start with count=1, Z=22'h00000A, type=0 -> sum=26'h000000A, max=22'h00000A.
